// File: rtl/phy_mgmt_seq.sv
// PHY management sequencer: after a settle delay it programs the RGMII PHY
// through mdio_master (optional GBCR clear, then BMCR autoneg restart) and
// then polls BMSR periodically to publish link_up / an_complete.
module phy_mgmt_seq #(
  parameter logic [4:0]  PHY_ADDR      = 5'h00,
  parameter int unsigned STARTUP_DELAY = 1048575,
  parameter int unsigned POLL_PERIOD   = 12500000,
  parameter int unsigned READ_TIMEOUT  = 4095,
  parameter bit          DISABLE_1G    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0]  cmd_opcode,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready,
  output logic        init_done,
  output logic        link_up,
  output logic        an_complete,
  output logic [7:0]  timeout_cnt
);

  localparam logic [1:0]  OP_WR    = 2'b01;
  localparam logic [1:0]  OP_RD    = 2'b10;
  localparam logic [23:0] DELAY_LD = 24'(STARTUP_DELAY);
  localparam logic [23:0] POLL_LD  = 24'(POLL_PERIOD);
  localparam logic [23:0] TMO_LD   = 24'(READ_TIMEOUT);

  typedef enum logic [2:0] {
    S_DELAY, S_WR_GBCR, S_WR_BMCR, S_POLL_WAIT, S_RD_ISSUE, S_RD_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        vld_d, init_d, link_d, an_d;
  logic [4:0]  reg_d;
  logic [15:0] data_d;
  logic [1:0]  op_d;
  logic [7:0]  tmo_d;
  logic        hs;

  // Only BMSR bits 2 and 5 are of interest; the rest of the read word is dropped.
  logic unused_bmsr_bits;
  assign unused_bmsr_bits = ^{data_out[15:6], data_out[4:3], data_out[1:0]};

  assign cmd_phy_addr   = PHY_ADDR;
  assign data_out_ready = 1'b1;
  assign hs             = cmd_valid && cmd_ready;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-state, counter, status and command-field computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | restart;
    init_d  = init_done;
    link_d  = link_up;
    an_d    = an_complete;
    tmo_d   = timeout_cnt;
    reg_d   = cmd_reg_addr;
    data_d  = cmd_data;
    op_d    = cmd_opcode;

    case (state_q)
      S_DELAY: begin
        if (cnt_q == 24'd0) state_d = DISABLE_1G ? S_WR_GBCR : S_WR_BMCR;
        else                cnt_d   = cnt_q - 24'd1;
      end
      S_WR_GBCR: begin
        if (hs) state_d = S_WR_BMCR;
      end
      S_WR_BMCR: begin
        // This write is the renegotiation itself, so any pending restart is absorbed.
        if (hs) begin
          state_d = S_POLL_WAIT;
          cnt_d   = POLL_LD;
          init_d  = 1'b1;
          pend_d  = 1'b0;
        end
      end
      S_POLL_WAIT: begin
        if (pend_q || restart) begin
          state_d = S_WR_BMCR;
          link_d  = 1'b0;
          an_d    = 1'b0;
          pend_d  = 1'b0;
        end else if (cnt_q == 24'd0) begin
          state_d = S_RD_ISSUE;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_RD_ISSUE: begin
        if (hs) begin
          state_d = S_RD_WAIT;
          cnt_d   = TMO_LD;
        end
      end
      S_RD_WAIT: begin
        // Read data takes priority over a timeout expiring in the same cycle.
        if (data_out_valid) begin
          link_d  = data_out[2];
          an_d    = data_out[5];
          state_d = S_POLL_WAIT;
          cnt_d   = POLL_LD;
        end else if (cnt_q == 24'd0) begin
          link_d  = 1'b0;
          an_d    = 1'b0;
          tmo_d   = sat_inc8(timeout_cnt);
          state_d = S_POLL_WAIT;
          cnt_d   = POLL_LD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d = S_DELAY;
        cnt_d   = DELAY_LD;
      end
    endcase

    // Fields only change on a state change, which only follows a handshake,
    // so they stay stable while a request is outstanding.
    case (state_d)
      S_WR_GBCR:  begin reg_d = 5'd9; data_d = 16'h0000; op_d = OP_WR; end
      S_WR_BMCR:  begin reg_d = 5'd0; data_d = 16'h1340; op_d = OP_WR; end
      S_RD_ISSUE: begin reg_d = 5'd1; data_d = 16'h0000; op_d = OP_RD; end
      default:    ;
    endcase

    // Request drops for one cycle after every accepted command.
    vld_d = ((state_d == S_WR_GBCR) || (state_d == S_WR_BMCR) ||
             (state_d == S_RD_ISSUE)) && !hs;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_DELAY;
      cnt_q        <= DELAY_LD;
      pend_q       <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_reg_addr <= 5'd0;
      cmd_data     <= 16'h0000;
      cmd_opcode   <= OP_WR;
      init_done    <= 1'b0;
      link_up      <= 1'b0;
      an_complete  <= 1'b0;
      timeout_cnt  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      cmd_valid    <= vld_d;
      cmd_reg_addr <= reg_d;
      cmd_data     <= data_d;
      cmd_opcode   <= op_d;
      init_done    <= init_d;
      link_up      <= link_d;
      an_complete  <= an_d;
      timeout_cnt  <= tmo_d;
    end
  end

endmodule
